ula_seq_unit: RTL
=================

Name: ula_seq_unit

Overview:
Parametrised, handshaked successor of the datapath ALU (ULA) for the bytecode processor. It registers operands and opcode on a start pulse and executes the same 16-entry opcode map, now with a real iterative divider, remainder output, correct ±1/+2 arithmetic and width-correct flags. It sits between the operand/stack muxes and the control FSM. The control FSM waits on done instead of assuming single-cycle results.

Parameters:
DATA_WIDTH, 8, architectural data width; overflow threshold is 2^DATA_WIDTH-1
ULA_WIDTH, 24, operand/result width (must be >= DATA_WIDTH, >= 2)

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request; accepted only when busy=0
sel_ula  in  4  opcode, sampled with start
in_1  in  ULA_WIDTH  operand 1 (regJump/regOp1 side), sampled with start
in_2  in  ULA_WIDTH  operand 2 (PC/TOS/arg/regOp2 side), sampled with start
busy  out  1  high from acceptance until done cycle inclusive
done  out  1  one-cycle pulse, results valid from this cycle
ula_out  out  ULA_WIDTH  result (quotient for DIV)
rem_out  out  ULA_WIDTH  remainder (DIV only; else 0)
comp_out  out  1  compare flag
overflow_out  out  1  arithmetic overflow flag
div_zero_out  out  1  divide-by-zero flag

Behaviour:
- Reset: all outputs 0, FSM to IDLE; takes priority over everything, including an in-flight divide (aborted, no done).
- FSM: IDLE -> EXEC (any opcode except DIV with in_1!=0) or -> DIV (DIV, in_1!=0); EXEC -> DONE; DIV counts ULA_WIDTH iterations -> DONE; DONE -> IDLE.
- start while busy=1 is ignored. Operands are latched, so input changes after acceptance have no effect.
- Latency: single-cycle ops raise done 2 clocks after the accepting edge. DIV raises done ULA_WIDTH+2 clocks after it. DIV by zero takes the EXEC path (2 clocks).
- Back-to-back: start may be asserted in the DONE cycle. busy is still 1, so it is ignored. Next acceptance is in IDLE.
- Opcodes, with A=in_1 and B=in_2. All arithmetic is unsigned and truncated to ULA_WIDTH:
  0000 B+A
  0001 B-A
  0010 B*A (low ULA_WIDTH bits of the 2*ULA_WIDTH product)
  0011 B/A, rem_out=B%A (restoring, one bit per cycle, MSB first)
  0100 A
  0101 B
  0110 B+1
  0111 B-1
  1000 B+2
  1001 comp=(B==A)
  1010 comp=(B<A)
  1011 comp=(B>A)
  1100 ~A
  1101 B&A
  1110 B|A
  1111 B^A
- Compare ops (1001-1011): ula_out = zero-extended comp bit; comp_out updated.
- Non-compare ops: comp_out holds its value.
- overflow_out is updated only by 0000-0011, and holds otherwise:
  - ADD: set when the full (ULA_WIDTH+1)-bit sum > 2^DATA_WIDTH-1.
  - SUB: set when B<A (borrow).
  - MULT: set when the full product > 2^DATA_WIDTH-1.
  - DIV: set only on divide-by-zero.
- Divide by zero: ula_out = all ones, rem_out = B, div_zero_out = 1, overflow_out = 1.
- div_zero_out is cleared by any other accepted opcode.
- ula_out and rem_out update only in the DONE cycle and hold until the next DONE or reset.

Decomposition:
- Package ula_pkg holds:
  - opcode localparams (OP_ADD..OP_XOR);
  - FSM state encoding (IDLE, EXEC, DIV, DONE);
  - a function returning the 2^DATA_WIDTH-1 threshold.
- Sub-module ula_divider holds the iterative restoring divider:
  - start/busy/done handshake, shared rst;
  - parameter ULA_WIDTH;
  - outputs quotient and remainder.
- The top level holds the single-cycle datapath, flags and FSM.

Test Plan:
- Reset mid-DIV: rst high 1 cycle at iteration 10 -> busy=0, all outputs 0, no done pulse. Next ADD 1+1 -> ula_out=2.
- ADD A=100, B=200 -> done after 2 clocks, ula_out=300, overflow_out=1. Then XOR A=0x0F, B=0xFF -> ula_out=0xF0, overflow_out stays 1.
- SUB A=5, B=3 -> ula_out=0xFFFFFE, overflow_out=1. Then LT A=5, B=3 -> comp_out=1, ula_out=1.
- DIV A=7, B=200 -> busy 26 clocks, done exactly 26 clocks after acceptance, ula_out=28, rem_out=4, overflow_out=0.
- DIV A=0, B=9 -> done after 2 clocks, ula_out=0xFFFFFF, rem_out=9, div_zero_out=1, overflow_out=1. Then ADD 1+2 -> div_zero_out=0.
- start re-pulsed every cycle during a DIV with different operands -> ignored; the first result is intact. PLUS1/LESS1/PLUS2 with B=0xFFFFFF -> 0, 0xFFFFFE, 1.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the sequential ULA: opcode map, FSM encoding and
// the overflow threshold helper.
package ula_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_MULT   = 4'b0010;
  localparam logic [3:0] OP_DIV    = 4'b0011;
  localparam logic [3:0] OP_PASS_A = 4'b0100;
  localparam logic [3:0] OP_PASS_B = 4'b0101;
  localparam logic [3:0] OP_PLUS1  = 4'b0110;
  localparam logic [3:0] OP_LESS1  = 4'b0111;
  localparam logic [3:0] OP_PLUS2  = 4'b1000;
  localparam logic [3:0] OP_EQ     = 4'b1001;
  localparam logic [3:0] OP_LT     = 4'b1010;
  localparam logic [3:0] OP_GT     = 4'b1011;
  localparam logic [3:0] OP_NOT    = 4'b1100;
  localparam logic [3:0] OP_AND    = 4'b1101;
  localparam logic [3:0] OP_OR     = 4'b1110;
  localparam logic [3:0] OP_XOR    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Largest value representable in the architectural data width.
  function automatic logic [63:0] ovf_threshold(input int unsigned data_width);
    return (64'd1 << data_width) - 64'd1;
  endfunction

endpackage

// File: rtl/ula_divider.sv
// Iterative restoring divider: one quotient bit per clock, MSB first.
// start is taken only while idle; done pulses for one cycle with results.
module ula_divider #(
  parameter int ULA_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ULA_WIDTH-1:0] dividend,
  input  logic [ULA_WIDTH-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [ULA_WIDTH-1:0] quotient,
  output logic [ULA_WIDTH-1:0] remainder
);

  localparam int CW = $clog2(ULA_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(ULA_WIDTH - 1);

  logic [ULA_WIDTH-1:0] quo_q, quo_d;
  logic [ULA_WIDTH-1:0] rem_q, rem_d;
  logic [ULA_WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [ULA_WIDTH:0]   partial;
  logic [ULA_WIDTH:0]   trial;

  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    // Partial remainder is one bit wider so the trial subtract never wraps.
    partial = {rem_q, quo_q[ULA_WIDTH-1]};
    trial   = partial - {1'b0, dvs_q};
    if (start && !busy_q) begin
      quo_d  = dividend;
      rem_d  = '0;
      dvs_d  = divisor;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (trial[ULA_WIDTH]) begin
        rem_d = partial[ULA_WIDTH-1:0];
        quo_d = {quo_q[ULA_WIDTH-2:0], 1'b0};
      end else begin
        rem_d = trial[ULA_WIDTH-1:0];
        quo_d = {quo_q[ULA_WIDTH-2:0], 1'b1};
      end
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/ula_seq_unit.sv
// Handshaked bytecode-processor ALU: latches operands on start, runs single-cycle
// ops through EXEC or non-zero divides through the iterative divider, pulses done.
// Handshake: start is accepted only in a cycle where busy=0; busy stays high
// from the accepting edge through the done cycle; done is a one-cycle pulse.
module ula_seq_unit
  import ula_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ULA_WIDTH  = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           sel_ula,
  input  logic [ULA_WIDTH-1:0] in_1,
  input  logic [ULA_WIDTH-1:0] in_2,
  output logic                 busy,
  output logic                 done,
  output logic [ULA_WIDTH-1:0] ula_out,
  output logic [ULA_WIDTH-1:0] rem_out,
  output logic                 comp_out,
  output logic                 overflow_out,
  output logic                 div_zero_out
);

  localparam int PW = 2 * ULA_WIDTH;
  localparam logic [PW-1:0]        THR = PW'(ovf_threshold(DATA_WIDTH));
  localparam logic [ULA_WIDTH-1:0] ONE = ULA_WIDTH'(1);
  localparam logic [ULA_WIDTH-1:0] TWO = ULA_WIDTH'(2);

  state_e               state_q, state_d;
  logic [ULA_WIDTH-1:0] a_q, a_d;
  logic [ULA_WIDTH-1:0] b_q, b_d;
  logic [3:0]           op_q, op_d;
  logic [ULA_WIDTH-1:0] ula_q, ula_d;
  logic [ULA_WIDTH-1:0] rem_q, rem_d;
  logic                 comp_q, comp_d;
  logic                 ovf_q, ovf_d;
  logic                 dz_q, dz_d;

  logic                 accept;
  logic                 div_start;
  logic                 div_busy;
  logic                 div_done;
  logic [ULA_WIDTH-1:0] div_quo;
  logic [ULA_WIDTH-1:0] div_rem;

  logic [ULA_WIDTH:0]   sum_full;
  logic [PW-1:0]        prod_full;
  logic [ULA_WIDTH-1:0] alu_res;
  logic                 alu_cmp;
  logic                 alu_is_cmp;
  logic                 alu_ovf;

  assign accept    = start && (state_q == IDLE);
  assign div_start = accept && (sel_ula == OP_DIV) && (in_1 != '0);

  ula_divider #(
    .ULA_WIDTH(ULA_WIDTH)
  ) u_divider (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (in_2),
    .divisor  (in_1),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  assign sum_full  = {1'b0, b_q} + {1'b0, a_q};
  assign prod_full = {{ULA_WIDTH{1'b0}}, b_q} * {{ULA_WIDTH{1'b0}}, a_q};

  // Single-cycle datapath on the latched operands; DIV here means divide by zero.
  always_comb begin
    alu_res    = '0;
    alu_cmp    = 1'b0;
    alu_is_cmp = 1'b0;
    alu_ovf    = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = sum_full[ULA_WIDTH-1:0];
        alu_ovf = PW'(sum_full) > THR;
      end
      OP_SUB: begin
        alu_res = b_q - a_q;
        alu_ovf = b_q < a_q;
      end
      OP_MULT: begin
        alu_res = prod_full[ULA_WIDTH-1:0];
        alu_ovf = prod_full > THR;
      end
      OP_DIV: begin
        alu_res = '1;
        alu_ovf = 1'b1;
      end
      OP_PASS_A: alu_res = a_q;
      OP_PASS_B: alu_res = b_q;
      OP_PLUS1:  alu_res = b_q + ONE;
      OP_LESS1:  alu_res = b_q - ONE;
      OP_PLUS2:  alu_res = b_q + TWO;
      OP_EQ: begin
        alu_is_cmp = 1'b1;
        alu_cmp    = b_q == a_q;
      end
      OP_LT: begin
        alu_is_cmp = 1'b1;
        alu_cmp    = b_q < a_q;
      end
      OP_GT: begin
        alu_is_cmp = 1'b1;
        alu_cmp    = b_q > a_q;
      end
      OP_NOT: alu_res = ~a_q;
      OP_AND: alu_res = b_q & a_q;
      OP_OR:  alu_res = b_q | a_q;
      OP_XOR: alu_res = b_q ^ a_q;
      default: alu_res = '0;
    endcase
    if (alu_is_cmp) begin
      alu_res = {{(ULA_WIDTH-1){1'b0}}, alu_cmp};
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    ula_d   = ula_q;
    rem_d   = rem_q;
    comp_d  = comp_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = in_1;
          b_d     = in_2;
          op_d    = sel_ula;
          state_d = div_start ? DIV : EXEC;
          if (sel_ula != OP_DIV) begin
            dz_d = 1'b0;
          end
        end
      end
      EXEC: begin
        state_d = DONE;
        ula_d   = alu_res;
        rem_d   = (op_q == OP_DIV) ? b_q : '0;
        if (alu_is_cmp) begin
          comp_d = alu_cmp;
        end
        if (op_q[3:2] == 2'b00) begin
          ovf_d = alu_ovf;
        end
        if (op_q == OP_DIV) begin
          dz_d = 1'b1;
        end
      end
      DIV: begin
        if (div_done) begin
          state_d = DONE;
          ula_d   = div_quo;
          rem_d   = div_rem;
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      ula_q   <= '0;
      rem_q   <= '0;
      comp_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      ula_q   <= ula_d;
      rem_q   <= rem_d;
      comp_q  <= comp_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign busy         = (state_q != IDLE) || div_busy;
  assign done         = (state_q == DONE);
  assign ula_out      = ula_q;
  assign rem_out      = rem_q;
  assign comp_out     = comp_q;
  assign overflow_out = ovf_q;
  assign div_zero_out = dz_q;

endmodule
